// File: rtl/neuron_layer_seq.sv
// neuron_layer_seq: time-multiplexes one shared 9-input neuron datapath across a layer of neurons
module neuron_layer_seq #(
    parameter int WIDTH       = 32,
    parameter int NUM_NEURONS = 4,
    parameter int ADDR_W      = 8,
    parameter int IDX_W       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [9*WIDTH-1:0]   act_in,
    output logic                 busy,
    output logic                 done,
    output logic                 wmem_en,
    output logic [ADDR_W-1:0]    wmem_addr,
    input  logic [WIDTH-1:0]     wmem_data,
    output logic [9*WIDTH-1:0]   nrn_a,
    output logic [9*WIDTH-1:0]   nrn_w,
    output logic [WIDTH-1:0]     nrn_b,
    input  logic [WIDTH-1:0]     nrn_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDX_W-1:0]     out_idx
);
    typedef enum logic [2:0] {IDLE, FETCH, LAST, EVAL, OUT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [3:0]        j;
    logic [IDX_W-1:0]  k;

    assign busy      = state != IDLE;
    assign wmem_en   = state == FETCH;
    assign wmem_addr = base + ADDR_W'(j);

    // Layer sequencer; weights shift in from the top so w_1 lands in the lowest slot after nine captures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            nrn_a     <= '0;
            nrn_w     <= '0;
            nrn_b     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    nrn_a <= act_in;
                    k     <= '0;
                    base  <= '0;
                    j     <= '0;
                    state <= FETCH;
                end
                FETCH: begin
                    if (j != 4'd0) nrn_w <= {wmem_data, nrn_w[9*WIDTH-1:WIDTH]};
                    j     <= (j == 4'd9) ? 4'd0 : j + 4'd1;
                    state <= (j == 4'd9) ? LAST : FETCH;
                end
                LAST: begin
                    nrn_b <= wmem_data;
                    state <= EVAL;
                end
                EVAL: begin
                    out_data  <= nrn_y;
                    out_idx   <= k;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (k == IDX_W'(NUM_NEURONS - 1)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        k     <= k + 1'b1;
                        base  <= base + ADDR_W'(10);
                        j     <= '0;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_layer_seq.sv
// tb_neuron_layer_seq: table-driven scoreboard bench with neuron stub and synchronous weight memory
module tb_neuron_layer_seq;
    localparam int W = 32;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [9*W-1:0] act_in = '0;
    logic           busy, done, wmem_en;
    logic [7:0]     wmem_addr;
    logic [W-1:0]   wmem_data = '0;
    logic [9*W-1:0] nrn_a, nrn_w;
    logic [W-1:0]   nrn_b, nrn_y;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_data;
    logic [1:0]     out_idx;

    neuron_layer_seq #(.WIDTH(W), .NUM_NEURONS(N), .ADDR_W(8), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .act_in(act_in), .busy(busy), .done(done),
        .wmem_en(wmem_en), .wmem_addr(wmem_addr), .wmem_data(wmem_data),
        .nrn_a(nrn_a), .nrn_w(nrn_w), .nrn_b(nrn_b), .nrn_y(nrn_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [0:255];

    always @(posedge clk) if (wmem_en) wmem_data <= mem[wmem_addr];

    always_comb begin
        nrn_y = nrn_b;
        for (int i = 0; i < 9; i++) nrn_y = nrn_y + nrn_a[i*W +: W] * nrn_w[i*W +: W];
    end

    typedef struct {
        logic [W-1:0] a, w0s, b0, w1, b1, y0, y1;
    } vec_t;
    typedef struct {
        logic [1:0]   idx;
        logic [W-1:0] data;
    } exp_t;

    vec_t tbl [4];
    exp_t q [$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_output", 32'(out_idx), 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("out_idx", 32'(out_idx), 32'(e.idx));
                chk("out_data", out_data, e.data);
            end
        end
    end

    task automatic push_exp(input int v);
        q.push_back('{idx: 2'd0, data: tbl[v].y0});
        q.push_back('{idx: 2'd1, data: tbl[v].y1});
    endtask

    task automatic launch(input int v);
        for (int i = 0; i < 9; i++) begin
            mem[i]      = tbl[v].w0s + W'(i);
            mem[10 + i] = tbl[v].w1;
        end
        mem[9]  = tbl[v].b0;
        mem[19] = tbl[v].b1;
        act_in  = {9{tbl[v].a}};
        push_exp(v);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_wmem_en"}, 32'(wmem_en), 0);
        chk({nm, "_wmem_addr"}, 32'(wmem_addr), 0);
        chk({nm, "_nrn_a"}, 32'(|nrn_a), 0);
        chk({nm, "_nrn_w"}, 32'(|nrn_w), 0);
        chk({nm, "_nrn_b"}, nrn_b, 0);
        chk({nm, "_out_valid"}, 32'(out_valid), 0);
        chk({nm, "_out_data"}, out_data, 0);
        chk({nm, "_out_idx"}, 32'(out_idx), 0);
    endtask

    initial begin
        int prev, vcnt;
        logic [W-1:0] hd;
        logic [1:0]   hx;
        tbl[0] = '{a: 32'd1, w0s: 32'd1, b0: 32'd5, w1: 32'd2, b1: -32'sd3, y0: 32'd50, y1: 32'd15};
        tbl[1] = '{a: 32'd2, w0s: 32'd0, b0: 32'd0, w1: 32'd1, b1: 32'd10, y0: 32'd72, y1: 32'd28};
        tbl[2] = '{a: 32'hFFFF_FFFF, w0s: 32'd3, b0: 32'd100, w1: 32'hFFFF_FFFE, b1: 32'd0, y0: 32'd37, y1: 32'd18};
        tbl[3] = '{a: 32'h1000_0000, w0s: 32'd0, b0: 32'd1, w1: 32'd16, b1: 32'd7, y0: 32'h4000_0001, y1: 32'd7};
        #2 check_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        for (int v = 0; v < 4; v++) begin
            prev = done_cnt;
            launch(v);
            if (v == 0) begin
                for (int c = 1; c <= 27; c++) begin
                    @(negedge clk);
                    if (c <= 10) begin
                        chk("fetch0_en", 32'(wmem_en), 1);
                        chk("fetch0_addr", 32'(wmem_addr), 32'(c - 1));
                    end
                    if (c >= 14 && c <= 23) chk("fetch1_addr", 32'(wmem_addr), 32'(c - 4));
                    if (c == 11) chk("last_en", 32'(wmem_en), 0);
                    if (c == 12) chk("eval_valid", 32'(out_valid), 0);
                    if (c == 13) begin
                        chk("t13_valid", 32'(out_valid), 1);
                        chk("t13_data", out_data, 32'd50);
                        chk("t14_done_early", 32'(done), 0);
                    end
                    if (c == 26) begin
                        chk("t26_valid", 32'(out_valid), 1);
                        chk("t26_busy", 32'(busy), 1);
                    end
                    if (c == 27) begin
                        chk("t27_done", 32'(done), 1);
                        chk("t27_busy", 32'(busy), 0);
                    end
                end
            end else begin
                if (v == 1) begin
                    repeat (3) @(posedge clk);
                    #1 act_in = '1;
                    start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                end
                wait_done();
            end
            @(posedge clk); #1;
            chk("done_count", 32'(done_cnt - prev), 1);
            chk("queue_empty", 32'(q.size()), 0);
        end
        prev = done_cnt;
        out_ready = 1'b0;
        launch(1);
        vcnt = 0;
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk("bp_valid_seen", 32'(out_valid), 1);
        hd = out_data;
        hx = out_idx;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", out_data, hd);
            chk("bp_idx", 32'(out_idx), 32'(hx));
            chk("bp_wmem_en", 32'(wmem_en), 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done();
        push_exp(1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_en", 32'(wmem_en), 1);
        chk("b2b_addr", 32'(wmem_addr), 0);
        wait_done();
        @(posedge clk); #1;
        chk("b2b_done_count", 32'(done_cnt - prev), 2);
        chk("b2b_queue_empty", 32'(q.size()), 0);
        prev = done_cnt;
        launch(2);
        repeat (16) @(negedge clk);
        chk("abort_pre_addr", 32'(wmem_addr), 32'd12);
        rst = 1'b1;
        #1 check_zero("abort");
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("abort_no_valid", 32'(vcnt), 0);
        chk("abort_no_done", 32'(done_cnt - prev), 0);
        launch(3);
        wait_done();
        @(posedge clk); #1;
        chk("after_abort_done", 32'(done_cnt - prev), 1);
        chk("final_queue_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
